// File: rtl/cnn_inst_loader_if.sv
// rtl/cnn_inst_loader_if.sv - host link and executor port bundle for the CNN instruction loader
interface cnn_inst_loader_if #(
    parameter int PART_W = 32,
    parameter int PARTS  = 4,
    parameter int ADDR_W = 8
);
    logic [PART_W-1:0]        CNN_INST_PART;
    logic                     CNN_INST_PART_EN;
    logic [1:0]               CNN_CMD;
    logic                     CNN_CMD_EN;
    logic [ADDR_W-1:0]        cnn_inst_addr;
    logic [PART_W*PARTS-1:0]  cnn_inst_q;
    logic                     cnn_inst_start;
    logic                     cnn_inst_ready;
    logic [ADDR_W:0]          inst_count;
    logic                     busy;
    logic [2:0]               err;

    modport master (
        output CNN_INST_PART, CNN_INST_PART_EN, CNN_CMD, CNN_CMD_EN,
        output cnn_inst_addr, cnn_inst_ready,
        input  cnn_inst_q, cnn_inst_start, inst_count, busy, err
    );

    modport slave (
        input  CNN_INST_PART, CNN_INST_PART_EN, CNN_CMD, CNN_CMD_EN,
        input  cnn_inst_addr, cnn_inst_ready,
        output cnn_inst_q, cnn_inst_start, inst_count, busy, err
    );
endinterface

// File: rtl/cnn_inst_loader.sv
// rtl/cnn_inst_loader.sv - assembles host parts into instructions, stores them, hands off to executor
module cnn_inst_loader #(
    parameter int PART_W = 32,
    parameter int PARTS  = 4,
    parameter int ADDR_W = 8
) (
    input  logic             MT9D111_PCLK,
    input  logic             RESETN,
    cnn_inst_loader_if.slave bus
);
    localparam int INST_W = PART_W * PARTS;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int P_W    = (PARTS > 1) ? $clog2(PARTS) : 1;

    localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [P_W-1:0]  P_LAST     = P_W'(PARTS - 1);
    localparam logic [1:0]      CMD_CLEAR  = 2'd1;
    localparam logic [1:0]      CMD_START  = 2'd2;
    localparam logic [1:0]      CMD_FLUSH  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     inst_count_q, inst_count_d;
    logic [2:0]          err_q, err_d;
    logic                seen_low_q, seen_low_d;
    logic                start_q, start_d;
    logic [INST_W-1:0]   asm_q, asm_d;
    logic [INST_W-1:0]   inst_q_q, inst_q_d;
    logic                ram_we;
    logic                busy;

    logic [INST_W-1:0]   mem [DEPTH];

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        wr_ptr_d     = wr_ptr_q;
        inst_count_d = inst_count_q;
        err_d        = err_q;
        seen_low_d   = seen_low_q;
        start_d      = 1'b0;
        asm_d        = asm_q;
        ram_we       = 1'b0;
        inst_q_d     = mem[bus.cnn_inst_addr];

        // A command in the same cycle as a part always wins; the part is silently lost.
        if (bus.CNN_CMD_EN) begin
            if (busy) begin
                if (bus.CNN_CMD == CMD_CLEAR || bus.CNN_CMD == CMD_FLUSH) begin
                    err_d[2] = 1'b1;
                end
            end else begin
                case (bus.CNN_CMD)
                    CMD_CLEAR: begin
                        p_d          = '0;
                        wr_ptr_d     = '0;
                        inst_count_d = '0;
                        err_d        = '0;
                    end
                    CMD_FLUSH: begin
                        if (p_q != '0) begin
                            p_d      = '0;
                            err_d[1] = 1'b1;
                        end
                    end
                    CMD_START: begin
                        if (p_q != '0) begin
                            p_d      = '0;
                            err_d[1] = 1'b1;
                        end
                        if (inst_count_q != '0) begin
                            state_d = ST_ARM;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (bus.CNN_INST_PART_EN) begin
            if (busy) begin
                err_d[2] = 1'b1;
            end else begin
                asm_d[int'(p_q)*PART_W +: PART_W] = bus.CNN_INST_PART;
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (inst_count_q == COUNT_FULL) begin
                        err_d[0] = 1'b1;
                    end else begin
                        ram_we       = 1'b1;
                        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                        inst_count_d = inst_count_q + (ADDR_W+1)'(1);
                    end
                end else begin
                    p_d = p_q + P_W'(1);
                end
            end
        end

        case (state_q)
            ST_ARM: begin
                if (bus.cnn_inst_ready) begin
                    start_d    = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // The executor must visibly drop ready before its return to ready ends the run.
                if (seen_low_q && bus.cnn_inst_ready) begin
                    seen_low_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (!bus.cnn_inst_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge MT9D111_PCLK) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            wr_ptr_q     <= '0;
            inst_count_q <= '0;
            err_q        <= '0;
            seen_low_q   <= 1'b0;
            start_q      <= 1'b0;
            asm_q        <= '0;
            inst_q_q     <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            wr_ptr_q     <= wr_ptr_d;
            inst_count_q <= inst_count_d;
            err_q        <= err_d;
            seen_low_q   <= seen_low_d;
            start_q      <= start_d;
            asm_q        <= asm_d;
            inst_q_q     <= inst_q_d;
        end
    end

    // RAM has no reset; the read above samples the pre-write contents on a same-address collision.
    always_ff @(posedge MT9D111_PCLK) begin
        if (RESETN && ram_we) begin
            mem[wr_ptr_q] <= asm_d;
        end
    end

    assign bus.cnn_inst_q     = inst_q_q;
    assign bus.cnn_inst_start = start_q;
    assign bus.inst_count     = inst_count_q;
    assign bus.busy           = busy;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_cnn_inst_loader.sv
// tb/tb_cnn_inst_loader.sv - directed and randomized bench for cnn_inst_loader against a queue-based model
module tb_cnn_inst_loader;
    localparam int PW = 32;
    localparam int NP = 4;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cnn_inst_loader_if #(.PART_W(PW), .PARTS(NP), .ADDR_W(AW)) bus();

    cnn_inst_loader #(.PART_W(PW), .PARTS(NP), .ADDR_W(AW)) dut (
        .MT9D111_PCLK (clk),
        .RESETN       (resetn),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] m_ram [DEPTH];
    bit           m_valid [DEPTH];
    logic [31:0]  m_parts [$];
    int           m_count = 0;
    logic [2:0]   m_err = '0;
    int           m_phase = 0;
    bit           m_seen = 1'b0;
    bit           m_start = 1'b0;
    logic [127:0] m_q = '0;
    bit           m_qv = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int         old_phase;
        logic [127:0] nq;
        bit         nqv;
        logic [127:0] w;
        @(posedge clk);
        old_phase = m_phase;
        nq  = m_ram[bus.cnn_inst_addr];
        nqv = m_valid[bus.cnn_inst_addr];
        if (!resetn) begin
            m_parts.delete();
            m_count = 0; m_err = '0; m_phase = 0; m_seen = 0; m_start = 0;
            nq = '0; nqv = 1'b1;
        end else begin
            if (bus.CNN_CMD_EN) begin
                if (old_phase != 0) begin
                    if (bus.CNN_CMD == 2'd1 || bus.CNN_CMD == 2'd3) m_err[2] = 1'b1;
                end else begin
                    case (bus.CNN_CMD)
                        2'd1: begin m_parts.delete(); m_count = 0; m_err = '0; end
                        2'd2: begin
                            if (m_parts.size() != 0) begin m_err[1] = 1'b1; m_parts.delete(); end
                            if (m_count != 0) m_phase = 1;
                        end
                        2'd3: if (m_parts.size() != 0) begin m_err[1] = 1'b1; m_parts.delete(); end
                        default: ;
                    endcase
                end
            end else if (bus.CNN_INST_PART_EN) begin
                if (old_phase != 0) m_err[2] = 1'b1;
                else begin
                    m_parts.push_back(bus.CNN_INST_PART);
                    if (m_parts.size() == NP) begin
                        if (m_count == DEPTH) m_err[0] = 1'b1;
                        else begin
                            w = '0;
                            foreach (m_parts[i]) w[i*PW +: PW] = m_parts[i];
                            m_ram[m_count] = w;
                            m_valid[m_count] = 1'b1;
                            m_count++;
                        end
                        m_parts.delete();
                    end
                end
            end
            m_start = 1'b0;
            if (old_phase == 1) begin
                if (bus.cnn_inst_ready) begin m_start = 1'b1; m_phase = 2; m_seen = 0; end
            end else if (old_phase == 2) begin
                if (m_seen && bus.cnn_inst_ready) begin m_phase = 0; m_seen = 0; end
                else if (!bus.cnn_inst_ready) m_seen = 1'b1;
            end
        end
        m_q = nq; m_qv = nqv;
        #1;
        chk("start", 128'(bus.cnn_inst_start), 128'(m_start));
        chk("count", 128'(bus.inst_count), 128'(m_count));
        chk("busy", 128'(bus.busy), 128'(m_phase != 0));
        chk("err", 128'(bus.err), 128'(m_err));
        if (m_qv) chk("q", bus.cnn_inst_q, m_q);
    endtask

    task automatic part(input logic [31:0] v);
        bus.CNN_INST_PART = v; bus.CNN_INST_PART_EN = 1'b1;
        tick();
        bus.CNN_INST_PART_EN = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] c);
        bus.CNN_CMD = c; bus.CNN_CMD_EN = 1'b1;
        tick();
        bus.CNN_CMD_EN = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_w;
        logic [31:0]  r;
        foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_ram[i] = '0; end
        bus.CNN_INST_PART = '0; bus.CNN_INST_PART_EN = 1'b0;
        bus.CNN_CMD = '0; bus.CNN_CMD_EN = 1'b0;
        bus.cnn_inst_addr = '0; bus.cnn_inst_ready = 1'b0;

        // reset values
        tick(); tick();
        resetn = 1'b1;
        chk("rst_q", bus.cnn_inst_q, 128'd0);
        chk("rst_count", 128'(bus.inst_count), 128'd0);
        chk("rst_busy_err", 128'({bus.busy, bus.cnn_inst_start, bus.err}), 128'd0);

        // load and read back
        cmd(2'd1);
        for (int i = 1; i <= 8; i++) part(32'(i));
        chk("load_count", 128'(bus.inst_count), 128'd2);
        bus.cnn_inst_addr = 2'd0; tick();
        chk("load_w0", bus.cnn_inst_q, 128'h00000004_00000003_00000002_00000001);
        bus.cnn_inst_addr = 2'd1; tick();
        chk("load_w1", bus.cnn_inst_q, 128'h00000008_00000007_00000006_00000005);

        // start handshake
        bus.cnn_inst_ready = 1'b1;
        cmd(2'd2);
        chk("hs_busy_t1", 128'({bus.busy, bus.cnn_inst_start}), 128'b10);
        tick();
        chk("hs_start_t2", 128'(bus.cnn_inst_start), 128'd1);
        bus.cnn_inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("hs_busy_low", 128'(bus.busy), 128'd1);
        bus.cnn_inst_ready = 1'b1;
        tick();
        chk("hs_done", 128'(bus.busy), 128'd0);
        tick();

        // partial and flush
        cmd(2'd1);
        for (int i = 0; i < 3; i++) part($urandom);
        cmd(2'd2);
        chk("pf_err", 128'(bus.err), 128'b010);
        tick(); tick();
        exp_w = '0;
        for (int i = 0; i < NP; i++) begin r = $urandom; exp_w[i*PW +: PW] = r; part(r); end
        bus.cnn_inst_addr = 2'd0; tick();
        chk("pf_word", bus.cnn_inst_q, exp_w);

        // overflow
        cmd(2'd1);
        exp_w = '0;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < NP; i++) begin
                r = $urandom;
                if (k == 0) exp_w[i*PW +: PW] = r;
                part(r);
            end
        chk("ov_count", 128'(bus.inst_count), 128'd4);
        chk("ov_err", 128'(bus.err), 128'b001);
        bus.cnn_inst_addr = 2'd0; tick();
        chk("ov_ram0", bus.cnn_inst_q, exp_w);

        // write while busy
        cmd(2'd2); tick();
        part($urandom);
        chk("wb_err", 128'(bus.err), 128'b101);
        chk("wb_count", 128'(bus.inst_count), 128'd4);
        cmd(2'd1);
        chk("wb_clear_dropped", 128'(bus.inst_count), 128'd4);
        bus.cnn_inst_ready = 1'b0; tick(); tick();
        bus.cnn_inst_ready = 1'b1; tick(); tick();

        // priority: command beats part
        cmd(2'd1);
        part($urandom); part($urandom);
        bus.CNN_INST_PART = $urandom; bus.CNN_INST_PART_EN = 1'b1;
        cmd(2'd1);
        bus.CNN_INST_PART_EN = 1'b0;
        chk("pri_count", 128'(bus.inst_count), 128'd0);
        exp_w = '0;
        for (int i = 0; i < NP; i++) begin r = $urandom; exp_w[i*PW +: PW] = r; part(r); end
        bus.cnn_inst_addr = 2'd0; tick();
        chk("pri_word", bus.cnn_inst_q, exp_w);

        // reset during ARM
        bus.cnn_inst_ready = 1'b0;
        cmd(2'd2);
        chk("arm_busy", 128'(bus.busy), 128'd1);
        resetn = 1'b0; bus.cnn_inst_ready = 1'b1;
        tick();
        resetn = 1'b1;
        chk("arm_rst", 128'({bus.busy, bus.cnn_inst_start, bus.err, bus.inst_count}), 128'd0);
        chk("arm_rst_q", bus.cnn_inst_q, 128'd0);
        tick(); tick();
        chk("arm_nostart", 128'(bus.cnn_inst_start), 128'd0);

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            bus.CNN_CMD_EN       = ($urandom_range(0, 9) == 0);
            bus.CNN_CMD          = 2'($urandom_range(0, 3));
            bus.CNN_INST_PART_EN = 1'($urandom_range(0, 1));
            bus.CNN_INST_PART    = $urandom;
            bus.cnn_inst_ready   = ($urandom_range(0, 3) != 0);
            bus.cnn_inst_addr    = 2'($urandom_range(0, 3));
            tick();
        end
        bus.CNN_CMD_EN = 1'b0; bus.CNN_INST_PART_EN = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
